// File: rtl/traffic_light_controller_if.sv
// Signal bundle between the traffic light controller and its environment.
// The master drives the timing strobe and requests; the slave returns the lamps and status.
interface traffic_light_controller_if #(
  parameter int TIMER_W = 5
);
  logic               tick;
  logic               ew_car;
  logic               ped_req;
  logic [2:0]         ns_light;
  logic [2:0]         ew_light;
  logic               ped_walk;
  logic [2:0]         phase;
  logic [TIMER_W-1:0] remaining;

  modport master (
    output tick, ew_car, ped_req,
    input  ns_light, ew_light, ped_walk, phase, remaining
  );

  modport slave (
    input  tick, ew_car, ped_req,
    output ns_light, ew_light, ped_walk, phase, remaining
  );
endinterface

// File: rtl/traffic_light_controller.sv
// Tick-driven Moore controller for one NS/EW intersection with a down-counting
// phase timer, an EW car sensor and a latched pedestrian request.
module traffic_light_controller #(
  parameter int TIMER_W  = 5,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 4,
  parameter int ALLRED_T = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  traffic_light_controller_if.slave tl
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5
  } state_t;

  localparam logic [TIMER_W-1:0] GREEN_RL  = TIMER_W'(GREEN_T - 1);
  localparam logic [TIMER_W-1:0] YELLOW_RL = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] ALLRED_RL = TIMER_W'(ALLRED_T - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_t             state_reg, state_next;
  logic [TIMER_W-1:0] remaining_reg, remaining_next;
  logic               ped_pend_reg, ped_pend_next;
  logic [2:0]         ns_reg, ns_next;
  logic [2:0]         ew_reg, ew_next;
  logic               walk_reg, walk_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RED_B;
      remaining_reg <= ALLRED_RL;
      ped_pend_reg  <= 1'b0;
      ns_reg        <= LAMP_RED;
      ew_reg        <= LAMP_RED;
      walk_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      ped_pend_reg  <= ped_pend_next;
      ns_reg        <= ns_next;
      ew_reg        <= ew_next;
      walk_reg      <= walk_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    ped_pend_next  = ped_pend_reg | tl.ped_req;

    // Codes 6-7 recover to the all-red clearance without waiting for a tick
    if (state_reg > RED_B) begin
      state_next     = RED_B;
      remaining_next = ALLRED_RL;
    end else if (tl.tick) begin
      if (remaining_reg != '0) begin
        remaining_next = remaining_reg - 1'b1;
      end else begin
        case (state_reg)
          NS_G:    state_next = (tl.ew_car || ped_pend_reg) ? NS_Y : NS_G;
          NS_Y:    state_next = RED_A;
          RED_A:   state_next = EW_G;
          EW_G:    state_next = EW_Y;
          EW_Y:    state_next = RED_B;
          default: state_next = NS_G;
        endcase
        case (state_next)
          NS_G, EW_G: remaining_next = GREEN_RL;
          NS_Y, EW_Y: remaining_next = YELLOW_RL;
          default:    remaining_next = ALLRED_RL;
        endcase
      end
    end

    // The request is served by this EW green; a press on the same edge still counts
    if (state_next == EW_G && state_reg != EW_G) begin
      ped_pend_next = tl.ped_req;
    end

    ns_next   = LAMP_RED;
    ew_next   = LAMP_RED;
    walk_next = 1'b0;
    case (state_next)
      NS_G: ns_next = LAMP_GREEN;
      NS_Y: ns_next = LAMP_YELLOW;
      EW_G: begin
        ew_next   = LAMP_GREEN;
        walk_next = 1'b1;
      end
      EW_Y: ew_next = LAMP_YELLOW;
      default: begin
        ns_next = LAMP_RED;
        ew_next = LAMP_RED;
      end
    endcase
  end

  assign tl.ns_light  = ns_reg;
  assign tl.ew_light  = ew_reg;
  assign tl.ped_walk  = walk_reg;
  assign tl.phase     = state_reg;
  assign tl.remaining = remaining_reg;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller: reset, NS hold, full cycle,
// pedestrian latch, tick hold and a random safety sweep.
module tb_traffic_light_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  traffic_light_controller_if #(.TIMER_W(5)) tl_if ();

  traffic_light_controller #(
    .TIMER_W (5),
    .GREEN_T (20),
    .YELLOW_T(4),
    .ALLRED_T(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tl (tl_if)
  );

  always #5 clk = ~clk;

  // Hand-computed per-phase expectations, indexed by phase code
  int         dur_tab [6] = '{20, 4, 2, 20, 4, 2};
  logic [2:0] ns_tab  [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab  [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  // Each tick is one strobe clock followed by one idle clock
  task automatic do_ticks(input int n);
    repeat (n) begin
      tl_if.tick = 1'b1;
      @(posedge clk); #1;
      tl_if.tick = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tl_if.ew_car = 1'b1;
    tl_if.ped_req = 1'b0;
    reset_dut();
    do_ticks(2 + 20 + 4 + 2 + 5);
    tests_run++;
    if (tl_if.phase !== 3'd3 || tl_if.remaining !== 5'd14) begin
      tests_failed++;
      $display("FAIL reset_setup phase=%0d rem=%0d want phase=3 rem=14", tl_if.phase, tl_if.remaining);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (tl_if.ns_light !== 3'b100 || tl_if.ew_light !== 3'b100 || tl_if.ped_walk !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_lamps ns=%b ew=%b walk=%b want 100/100/0", tl_if.ns_light, tl_if.ew_light, tl_if.ped_walk);
    end
    tests_run++;
    if (tl_if.phase !== 3'd5 || tl_if.remaining !== 5'd1) begin
      tests_failed++;
      $display("FAIL reset_state phase=%0d rem=%0d want phase=5 rem=1", tl_if.phase, tl_if.remaining);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_ticks(1);
    tests_run++;
    if (tl_if.phase !== 3'd5 || tl_if.remaining !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_tick1 phase=%0d rem=%0d want phase=5 rem=0", tl_if.phase, tl_if.remaining);
    end
    do_ticks(1);
    tests_run++;
    if (tl_if.phase !== 3'd0 || tl_if.remaining !== 5'd19 || tl_if.ns_light !== 3'b001) begin
      tests_failed++;
      $display("FAIL reset_to_nsg phase=%0d rem=%0d ns=%b want phase=0 rem=19 ns=001",
               tl_if.phase, tl_if.remaining, tl_if.ns_light);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_ns_hold();
    tl_if.ew_car = 1'b0;
    tl_if.ped_req = 1'b0;
    reset_dut();
    do_ticks(2);
    for (int k = 1; k <= 60; k++) begin
      do_ticks(1);
      tests_run++;
      if (tl_if.phase !== 3'd0 || tl_if.remaining !== 5'(19 - (k % 20)) || tl_if.ew_light !== 3'b100) begin
        tests_failed++;
        $display("FAIL ns_hold k=%0d phase=%0d rem=%0d ew=%b want phase=0 rem=%0d ew=100",
                 k, tl_if.phase, tl_if.remaining, tl_if.ew_light, 19 - (k % 20));
      end
    end
    $display("[TB] test_ns_hold done");
  endtask

  task automatic test_full_cycle();
    tl_if.ew_car = 1'b1;
    tl_if.ped_req = 1'b0;
    reset_dut();
    do_ticks(2);
    for (int p = 0; p < 6; p++) begin
      for (int r = dur_tab[p] - 1; r >= 0; r--) begin
        tests_run++;
        if (tl_if.phase !== 3'(p) || tl_if.remaining !== 5'(r)) begin
          tests_failed++;
          $display("FAIL cycle_state phase=%0d rem=%0d want phase=%0d rem=%0d", tl_if.phase, tl_if.remaining, p, r);
        end
        tests_run++;
        if (tl_if.ns_light !== ns_tab[p] || tl_if.ew_light !== ew_tab[p] || tl_if.ped_walk !== (p == 3)) begin
          tests_failed++;
          $display("FAIL cycle_lamps phase=%0d ns=%b ew=%b walk=%b want ns=%b ew=%b walk=%b",
                   p, tl_if.ns_light, tl_if.ew_light, tl_if.ped_walk, ns_tab[p], ew_tab[p], p == 3);
        end
        do_ticks(1);
      end
    end
    tests_run++;
    if (tl_if.phase !== 3'd0 || tl_if.remaining !== 5'd19) begin
      tests_failed++;
      $display("FAIL cycle_period phase=%0d rem=%0d want phase=0 rem=19", tl_if.phase, tl_if.remaining);
    end
    $display("[TB] test_full_cycle done");
  endtask

  task automatic test_ped_request();
    tl_if.ew_car = 1'b0;
    tl_if.ped_req = 1'b0;
    reset_dut();
    do_ticks(2 + 5);
    tl_if.ped_req = 1'b1;
    @(posedge clk); #1;
    tl_if.ped_req = 1'b0;
    do_ticks(14);
    tests_run++;
    if (tl_if.phase !== 3'd0 || tl_if.remaining !== 5'd0) begin
      tests_failed++;
      $display("FAIL ped_before_expiry phase=%0d rem=%0d want phase=0 rem=0", tl_if.phase, tl_if.remaining);
    end
    do_ticks(1);
    tests_run++;
    if (tl_if.phase !== 3'd1) begin
      tests_failed++;
      $display("FAIL ped_to_nsy phase=%0d want 1", tl_if.phase);
    end
    do_ticks(4 + 2);
    for (int k = 0; k < 20; k++) begin
      tests_run++;
      if (tl_if.phase !== 3'd3 || tl_if.ped_walk !== 1'b1) begin
        tests_failed++;
        $display("FAIL ped_walk k=%0d phase=%0d walk=%b want phase=3 walk=1", k, tl_if.phase, tl_if.ped_walk);
      end
      do_ticks(1);
    end
    tests_run++;
    if (tl_if.phase !== 3'd4 || tl_if.ped_walk !== 1'b0) begin
      tests_failed++;
      $display("FAIL ped_walk_end phase=%0d walk=%b want phase=4 walk=0", tl_if.phase, tl_if.ped_walk);
    end
    do_ticks(4 + 2 + 20);
    tests_run++;
    if (tl_if.phase !== 3'd0 || tl_if.remaining !== 5'd19) begin
      tests_failed++;
      $display("FAIL ped_cleared phase=%0d rem=%0d want phase=0 rem=19", tl_if.phase, tl_if.remaining);
    end
    $display("[TB] test_ped_request done");
  endtask

  task automatic test_ped_set_wins();
    tl_if.ew_car = 1'b0;
    tl_if.ped_req = 1'b0;
    reset_dut();
    do_ticks(2);
    tl_if.ped_req = 1'b1;
    @(posedge clk); #1;
    tl_if.ped_req = 1'b0;
    do_ticks(20 + 4 + 1);
    tests_run++;
    if (tl_if.phase !== 3'd2 || tl_if.remaining !== 5'd0) begin
      tests_failed++;
      $display("FAIL setwins_setup phase=%0d rem=%0d want phase=2 rem=0", tl_if.phase, tl_if.remaining);
    end
    tl_if.tick = 1'b1;
    tl_if.ped_req = 1'b1;
    @(posedge clk); #1;
    tl_if.tick = 1'b0;
    tl_if.ped_req = 1'b0;
    tests_run++;
    if (tl_if.phase !== 3'd3 || tl_if.ped_walk !== 1'b1) begin
      tests_failed++;
      $display("FAIL setwins_ewg phase=%0d walk=%b want phase=3 walk=1", tl_if.phase, tl_if.ped_walk);
    end
    do_ticks(20 + 4 + 2 + 20);
    tests_run++;
    if (tl_if.phase !== 3'd1 || tl_if.remaining !== 5'd3) begin
      tests_failed++;
      $display("FAIL setwins_rerun phase=%0d rem=%0d want phase=1 rem=3", tl_if.phase, tl_if.remaining);
    end
    $display("[TB] test_ped_set_wins done");
  endtask

  task automatic test_tick_hold();
    tl_if.ew_car = 1'b1;
    tl_if.ped_req = 1'b0;
    reset_dut();
    do_ticks(2 + 20 + 1);
    tests_run++;
    if (tl_if.phase !== 3'd1 || tl_if.remaining !== 5'd2) begin
      tests_failed++;
      $display("FAIL hold_setup phase=%0d rem=%0d want phase=1 rem=2", tl_if.phase, tl_if.remaining);
    end
    for (int k = 0; k < 100; k++) begin
      tl_if.ew_car  = 1'($urandom_range(0, 1));
      tl_if.ped_req = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      tests_run++;
      if (tl_if.phase !== 3'd1 || tl_if.remaining !== 5'd2 || tl_if.ns_light !== 3'b010) begin
        tests_failed++;
        $display("FAIL hold_clk k=%0d phase=%0d rem=%0d ns=%b want phase=1 rem=2 ns=010",
                 k, tl_if.phase, tl_if.remaining, tl_if.ns_light);
      end
    end
    tl_if.ped_req = 1'b0;
    do_ticks(1);
    tests_run++;
    if (tl_if.phase !== 3'd1 || tl_if.remaining !== 5'd1) begin
      tests_failed++;
      $display("FAIL hold_resume phase=%0d rem=%0d want phase=1 rem=1", tl_if.phase, tl_if.remaining);
    end
    $display("[TB] test_tick_hold done");
  endtask

  task automatic test_random_safety();
    for (int k = 0; k < 10000; k++) begin
      tl_if.tick    = 1'($urandom_range(0, 1));
      tl_if.ew_car  = 1'($urandom_range(0, 1));
      tl_if.ped_req = ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
      tests_run++;
      if ((tl_if.ns_light !== 3'b100 && tl_if.ew_light !== 3'b100) ||
          !$onehot(tl_if.ns_light) || !$onehot(tl_if.ew_light)) begin
        tests_failed++;
        $display("FAIL safety k=%0d ns=%b ew=%b want one-hot with at least one red", k, tl_if.ns_light, tl_if.ew_light);
      end
    end
    tl_if.tick = 1'b0;
    tl_if.ped_req = 1'b0;
    $display("[TB] test_random_safety done");
  endtask

  initial begin
    tl_if.tick    = 1'b0;
    tl_if.ew_car  = 1'b0;
    tl_if.ped_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_ns_hold();
    test_full_cycle();
    test_ped_request();
    test_ped_set_wins();
    test_tick_hold();
    test_random_safety();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
